// File: rtl/mips_pkg.sv
// Shared decode constants for the MIPS_uP sequencer: opcodes, IR field positions
// and FSM state encoding.
package mips_pkg;

  // Opcodes, IR[31:24]
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h10;
  localparam logic [7:0] OP_MUL   = 8'h02;
  localparam logic [7:0] OP_STORE = 8'h20;

  // IR field LSB positions
  localparam int unsigned IR_OP_LSB = 24;
  localparam int unsigned IR_OP_W   = 8;
  localparam int unsigned IR_RA_LSB = 20;
  localparam int unsigned IR_RB_LSB = 16;
  localparam int unsigned IR_MA_LSB = 5;

  // Width of the multiplier latency counter; holds MUL_LAT-1 for MUL_LAT up to 15
  localparam int unsigned LAT_CNT_W = 4;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_LD_RD    = 4'd1;
  localparam logic [3:0] ST_LD_WB    = 4'd2;
  localparam logic [3:0] ST_MUL_RD   = 4'd3;
  localparam logic [3:0] ST_MUL_WAIT = 4'd4;
  localparam logic [3:0] ST_MUL_WB   = 4'd5;
  localparam logic [3:0] ST_ST_RD    = 4'd6;
  localparam logic [3:0] ST_ST_WR    = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;
  localparam logic [3:0] ST_ILL      = 4'd9;

endpackage

// File: rtl/mips_seq_lat_cnt.sv
// Loadable down-counter with zero flag; times the multiplier result latency.
module mips_seq_lat_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load has priority; decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle instruction sequencer for the MIPS_uP datapath (RF, DM, multiplier).
// Optional macro MIPS_SEQ_CTRL_PERF_EN adds saturating perf_retired/perf_busy counters.
module mips_seq_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned RADDR_W = 4,
  parameter int unsigned MADDR_W = 8,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        ir,
  input  logic               ir_valid,
  output logic               ir_ready,
  output logic [RADDR_W-1:0] rf_addra,
  output logic [RADDR_W-1:0] rf_addrb,
  output logic               rf_we,
  output logic               rf_wsel,
  output logic [MADDR_W-1:0] mem_addr,
  output logic               mem_re,
  output logic               mem_we,
  output logic               mul_start,
  output logic               done,
  output logic               illegal
`ifdef MIPS_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]        perf_retired,
  output logic [15:0]        perf_busy
`endif
);

  localparam logic [LAT_CNT_W-1:0] LatLoad = LAT_CNT_W'(MUL_LAT - 1);

  logic [3:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        init_q;
  logic        accept;
  logic        lat_zero;
  logic [IR_OP_W-1:0] op;

  // ir_ready is held low until the first edge after reset release
  assign ir_ready = (state_q == ST_IDLE) && init_q;
  assign accept   = ir_valid && ir_ready;
  assign op       = ir[IR_OP_LSB +: IR_OP_W];

  // Next state and IR capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ir_d = ir;
          case (op)
            OP_NOP:   state_d = ST_DONE;
            OP_LOAD:  state_d = ST_LD_RD;
            OP_MUL:   state_d = ST_MUL_RD;
            OP_STORE: state_d = ST_ST_RD;
            default:  state_d = ST_ILL;
          endcase
        end
      end
      ST_LD_RD:    state_d = ST_LD_WB;
      ST_LD_WB:    state_d = ST_DONE;
      ST_MUL_RD:   state_d = ST_MUL_WAIT;
      ST_MUL_WAIT: if (lat_zero) state_d = ST_MUL_WB;
      ST_MUL_WB:   state_d = ST_DONE;
      ST_ST_RD:    state_d = ST_ST_WR;
      ST_ST_WR:    state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      ST_ILL:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State, IR latch and post-reset ready gate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      init_q  <= 1'b1;
    end
  end

  mips_seq_lat_cnt #(
    .Width (LAT_CNT_W)
  ) u_lat_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (state_q == ST_MUL_RD),
    .load_val_i (LatLoad),
    .dec_i      (state_q == ST_MUL_WAIT),
    .zero_o     (lat_zero)
  );

  // Moore strobes decoded from the current state
  always_comb begin
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mul_start = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      ST_LD_RD:  mem_re = 1'b1;
      ST_LD_WB:  rf_we = 1'b1;
      ST_MUL_RD: mul_start = 1'b1;
      ST_MUL_WB: begin
        rf_we   = 1'b1;
        rf_wsel = 1'b1;
      end
      ST_ST_WR:  mem_we = 1'b1;
      ST_DONE:   done = 1'b1;
      ST_ILL:    illegal = 1'b1;
      default:   ;
    endcase
  end

  assign rf_addra = ir_q[IR_RA_LSB +: RADDR_W];
  assign rf_addrb = ir_q[IR_RB_LSB +: RADDR_W];
  assign mem_addr = ir_q[IR_MA_LSB +: MADDR_W];

  // Opcode and spare IR bits are decoded from the live input, not from ir_q
  logic unused_ir_q;
  assign unused_ir_q = ^ir_q;

`ifdef MIPS_SEQ_CTRL_PERF_EN
  logic [15:0] retired_q, retired_d, busy_q, busy_d;

  // Saturating retire and busy-cycle counters
  always_comb begin
    retired_d = retired_q;
    busy_d    = busy_q;
    if ((state_q == ST_DONE) && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
    if ((state_q != ST_IDLE) && (busy_q != 16'hFFFF))    busy_d    = busy_q + 16'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
      busy_q    <= '0;
    end else begin
      retired_q <= retired_d;
      busy_q    <= busy_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_busy    = busy_q;
`endif

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed self-checking bench for mips_seq_ctrl (default build, MUL_LAT = 2).
module tb_mips_seq_ctrl;

  localparam int unsigned RADDR_W = 4;
  localparam int unsigned MADDR_W = 8;
  localparam int unsigned MUL_LAT = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [31:0]        ir = '0;
  logic               ir_valid = 1'b0;
  logic               ir_ready;
  logic [RADDR_W-1:0] rf_addra;
  logic [RADDR_W-1:0] rf_addrb;
  logic               rf_we;
  logic               rf_wsel;
  logic [MADDR_W-1:0] mem_addr;
  logic               mem_re;
  logic               mem_we;
  logic               mul_start;
  logic               done;
  logic               illegal;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  logic watch  = 1'b0;
  logic saw_we = 1'b0;

  // {ir_ready, rf_we, rf_wsel, mem_re, mem_we, mul_start, done, illegal}
  wire [7:0] st = {ir_ready, rf_we, rf_wsel, mem_re, mem_we, mul_start, done, illegal};

  mips_seq_ctrl #(
    .RADDR_W (RADDR_W),
    .MADDR_W (MADDR_W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .rf_addra  (rf_addra),
    .rf_addrb  (rf_addrb),
    .rf_we     (rf_we),
    .rf_wsel   (rf_wsel),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mul_start (mul_start),
    .done      (done),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Sticky record of any RF write while watching
  always @(posedge clk) if (watch && rf_we) saw_we <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present ir for one accept edge, then drop valid
  task automatic issue(input logic [31:0] word);
    ir       = word;
    ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0;
  endtask

  initial begin
    // Reset asserted between edges
    #2 rst_n = 1'b0;
    #1;
    chk("rst st", st, 8'h00);
    chk("rst addra", rf_addra, 0);
    chk("rst maddr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rel rdy low", st, 8'h00);
    tick();
    chk("rel rdy", st, 8'h80);

    // LOAD RF[A] <- DM[0xFF]
    issue(32'h10A0_1FE0);
    chk("ld+1 st", st, 8'h10);
    chk("ld+1 maddr", mem_addr, 8'hFF);
    tick();
    chk("ld+2 st", st, 8'h40);
    chk("ld+2 addra", rf_addra, 4'hA);
    tick();
    chk("ld+3 st", st, 8'h02);
    tick();
    chk("ld+4 st", st, 8'h80);

    // MUL RF[0] <- RF[0]*RF[1]
    issue(32'h0201_0000);
    chk("mul+1 st", st, 8'h04);
    chk("mul+1 addra", rf_addra, 4'h0);
    chk("mul+1 addrb", rf_addrb, 4'h1);
    tick();
    chk("mul+2 st", st, 8'h00);
    tick();
    chk("mul+3 st", st, 8'h00);
    tick();
    chk("mul+4 st", st, 8'h60);
    tick();
    chk("mul+5 st", st, 8'h02);
    tick();
    chk("mul+6 st", st, 8'h80);

    // STORE DM[3] <- RF[0]; ir changes mid-instruction
    issue(32'h2000_0060);
    chk("st+1 st", st, 8'h00);
    ir = 32'h10FF_1FE0;
    tick();
    chk("st+2 st", st, 8'h08);
    chk("st+2 maddr", mem_addr, 8'h03);
    chk("st+2 addra", rf_addra, 4'h0);
    tick();
    chk("st+3 st", st, 8'h02);
    tick();
    chk("st+4 st", st, 8'h80);
    chk("st+4 maddr hold", mem_addr, 8'h03);

    // Illegal, then NOP held valid back-to-back
    ir       = 32'hFF00_0000;
    ir_valid = 1'b1;
    tick();
    ir = 32'h0000_0000;
    chk("ill+1 st", st, 8'h01);
    tick();
    chk("ill+2 st", st, 8'h80);
    tick();
    chk("nop+1 st", st, 8'h02);
    ir_valid = 1'b0;
    tick();
    chk("nop+2 st", st, 8'h80);

    // Reset in MUL_WAIT abandons the write
    issue(32'h0253_0000);
    chk("mr+1 st", st, 8'h04);
    chk("mr+1 addra", rf_addra, 4'h5);
    chk("mr+1 addrb", rf_addrb, 4'h3);
    tick();
    chk("mr+2 st", st, 8'h00);
    watch = 1'b1;
    #4 rst_n = 1'b0;
    #1;
    chk("mr rst st", st, 8'h00);
    chk("mr rst addra", rf_addra, 4'h0);
    chk("mr rst addrb", rf_addrb, 4'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("mr rel st", st, 8'h80);
    repeat (4) tick();
    chk("mr idle st", st, 8'h80);
    chk("mr no we", saw_we, 1'b0);
    watch = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_seq_ctrl.md
Name: mips_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the MIPS_uP micro-datapath: register file (RF), data memory (DM) and multiplier.
- Accepts one 32-bit IR word per transaction over a valid/ready handshake and decodes it.
- Drives the RF, DM and multiplier control strobes cycle by cycle until the instruction retires.
- Replaces direct IR-driven control; sits between the instruction source and the datapath.

Parameters:
- RADDR_W, 4, RF address width. addra = IR[23:20], addrb = IR[19:16]; RADDR_W ≤ 4, low bits used.
- MADDR_W, 8, DM address width. maddr = IR[5+MADDR_W-1:5].
- MUL_LAT, 2, multiplier result latency in cycles after operands are presented. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  32  instruction word.
- ir_valid  in  1  ir is valid.
- ir_ready  out  1  sequencer can accept ir.
- rf_addra  out  RADDR_W  RF read port A address; also the write address.
- rf_addrb  out  RADDR_W  RF read port B address.
- rf_we  out  1  RF write strobe.
- rf_wsel  out  1  RF write-data select: 0 = DM read data, 1 = multiplier result.
- mem_addr  out  MADDR_W  DM address.
- mem_re  out  1  DM read strobe; synchronous, data valid the next cycle.
- mem_we  out  1  DM write strobe; data is RF port A.
- mul_start  out  1  multiplier operand-capture strobe.
- done  out  1  one-cycle retire pulse.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Opcode is IR[31:24]:
  - 0x00 NOP
  - 0x10 LOAD: RF[addra] ← DM[maddr]
  - 0x02 MUL: RF[addra] ← RF[addra] × RF[addrb]
  - 0x20 STORE: DM[maddr] ← RF[addra]
  - any other value is illegal.
- ir_ready = 1 only in IDLE. Transfer occurs when ir_valid & ir_ready at a clock edge. IR is latched into ir_q and used for the whole instruction; ir changes mid-instruction are ignored.
- Address outputs are driven combinationally from ir_q fields and hold their last value in IDLE. They are zero after reset.
- States and transitions:
  - IDLE: on accept, branch by opcode to LD_RD, MUL_RD, ST_RD, DONE (NOP) or ILL.
  - LD_RD: mem_re = 1 → LD_WB.
  - LD_WB: rf_we = 1, rf_wsel = 0 → DONE.
  - MUL_RD: mul_start = 1, counter loaded with MUL_LAT-1 → MUL_WAIT.
  - MUL_WAIT: decrement the counter; at 0 → MUL_WB. With MUL_LAT = 1, MUL_WAIT lasts 1 cycle.
  - MUL_WB: rf_we = 1, rf_wsel = 1 → DONE.
  - ST_RD: RF port A settles → ST_WR.
  - ST_WR: mem_we = 1 → DONE.
  - DONE: done = 1 → IDLE.
  - ILL: illegal = 1 → IDLE; no strobes asserted.
- Latency from accept edge to done-high cycle, with ir_ready back the following cycle:
  - NOP: 1
  - LOAD: 3
  - STORE: 3
  - MUL: 3 + MUL_LAT
- All strobes are mutually exclusive and single-cycle per state.
- Reset, including mid-instruction, asynchronously forces:
  - state = IDLE, ir_q = 0, counter = 0
  - all strobes, done and illegal = 0
  - ir_ready goes to 1 after reset deasserts.
  - A partially executed instruction is abandoned; there is no write after reset.
- ir_valid held high back-to-back: the next IR is accepted on the first IDLE cycle.

Optional Feature:
- Macro: MIPS_SEQ_CTRL_PERF_EN.
- When defined, two extra output ports are present:
  - perf_retired (16-bit): counts done pulses, ILL excluded.
  - perf_busy (16-bit): counts cycles with state ≠ IDLE.
  - Both saturate at 0xFFFF, both reset to 0 on rst_n.
- When undefined: no ports, no counter logic. Core timing is identical in both cases.

Decomposition:
- Package mips_pkg holds:
  - opcode localparams OP_NOP, OP_LOAD, OP_MUL, OP_STORE
  - IR field bit positions
  - state encoding
- One natural sub-module: mips_seq_lat_cnt, the down-counter with load and zero flag, used for MUL_WAIT. Everything else stays in the FSM.

Test Plan:
- Reset: assert rst_n = 0 mid-clock → all outputs 0 immediately. Release → ir_ready = 1 next edge.
- LOAD: ir = 0x10000000 with 1-cycle valid → mem_re = 1, mem_addr = 0 at cycle +1; rf_we = 1, rf_wsel = 0, rf_addra = 0 at +2; done at +3.
- MUL (MUL_LAT = 2): ir = 0x02010000 → mul_start at +1 with rf_addra = 0, rf_addrb = 1; rf_we = 1, rf_wsel = 1 at +4; done at +5.
- STORE: ir = 0x20000060 → mem_we = 1, mem_addr = 3, rf_addra = 0 at +2; done at +3. ir changes during execution → no effect.
- Illegal and back-to-back: ir = 0xFF000000 → illegal pulse at +1, no strobes. Then NOP held valid → accepted at the first IDLE cycle, done 1 cycle later, ir_ready low between accepts.
- Reset mid-MUL: assert rst_n in MUL_WAIT → no rf_we ever issued, IDLE on release. With MIPS_SEQ_CTRL_PERF_EN, perf counters read 0.
